// File: rtl/avalon_pio_ext.sv
// avalon_pio_ext: Avalon-MM PIO with edge-capture interrupts and timed output pulses
module avalon_pio_ext #(
    parameter int unsigned OUT_WIDTH    = 2,
    parameter int unsigned IN_WIDTH     = 2,
    parameter logic [31:0] RESET_VALUE  = 32'd0,
    parameter int unsigned EDGE_TYPE    = 0,
    parameter int unsigned PULSE_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [2:0]           address,
    input  logic                 chipselect,
    input  logic                 write_n,
    input  logic [31:0]          writedata,
    output logic [31:0]          readdata,
    input  logic [IN_WIDTH-1:0]  in_port,
    output logic [OUT_WIDTH-1:0] out_port,
    output logic                 irq
);
    localparam logic IDLE   = 1'b0;
    localparam logic ACTIVE = 1'b1;
    localparam logic [OUT_WIDTH-1:0] DATA_RST = RESET_VALUE[OUT_WIDTH-1:0];
    localparam logic [15:0] CNT_LOAD = 16'(PULSE_CYCLES);

    logic                 wr;
    logic                 pulse_wr;
    logic                 expire;
    logic [OUT_WIDTH-1:0] wd_out;
    logic [IN_WIDTH-1:0]  wd_in;
    logic [IN_WIDTH-1:0]  edge_ev;
    logic                 unused;

    logic [OUT_WIDTH-1:0] data_q, data_d;
    logic [IN_WIDTH-1:0]  mask_q, mask_d;
    logic [IN_WIDTH-1:0]  edge_q, edge_d;
    logic [OUT_WIDTH-1:0] pulse_q, pulse_d;
    logic [15:0]          cnt_q, cnt_d;
    logic                 state_q, state_d;
    logic [1:0]           warm_q, warm_d;
    logic [IN_WIDTH-1:0]  sync1_q, sync2_q, prev_q;

    assign wr       = chipselect && !write_n;
    assign pulse_wr = wr && address == 3'd6;
    assign wd_out   = writedata[OUT_WIDTH-1:0];
    assign wd_in    = writedata[IN_WIDTH-1:0];
    assign unused   = ^writedata;

    // Output data register: direct write, set-bits and clear-bits views
    always_comb begin
        data_d = (wr && address == 3'd0) ? wd_out :
                 (wr && address == 3'd4) ? data_q | wd_out :
                 (wr && address == 3'd5) ? data_q & ~wd_out : data_q;
        mask_d = (wr && address == 3'd2) ? wd_in : mask_q;
    end

    // Edge detection is held off until the synchroniser and prev have refilled after reset,
    // so levels already present at reset release never look like edges
    always_comb begin
        edge_ev = (EDGE_TYPE == 0) ? sync2_q & ~prev_q :
                  (EDGE_TYPE == 1) ? ~sync2_q & prev_q : sync2_q ^ prev_q;
        edge_d  = (edge_q & ~((wr && address == 3'd3) ? wd_in : '0)) |
                  ((warm_q == 2'd3) ? edge_ev : '0);
        warm_d  = (warm_q == 2'd3) ? warm_q : warm_q + 2'd1;
    end

    // Pulse engine: a PULSE write always wins over expiry; zero mask cancels
    always_comb begin
        expire  = state_q == ACTIVE && cnt_q == 16'd1;
        pulse_d = pulse_wr ? wd_out : expire ? '0 : pulse_q;
        cnt_d   = pulse_wr ? (|wd_out ? CNT_LOAD : 16'd0) :
                  (state_q == ACTIVE) ? cnt_q - 16'd1 : cnt_q;
        state_d = pulse_wr ? (|wd_out ? ACTIVE : IDLE) : expire ? IDLE : state_q;
    end

    // All state registers with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q  <= DATA_RST;
            mask_q  <= '0;
            edge_q  <= '0;
            pulse_q <= '0;
            cnt_q   <= '0;
            state_q <= IDLE;
            warm_q  <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            data_q  <= data_d;
            mask_q  <= mask_d;
            edge_q  <= edge_d;
            pulse_q <= pulse_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            warm_q  <= warm_d;
            sync1_q <= in_port;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Zero-latency register read mux; write-only registers read as zero
    always_comb begin
        case (address)
            3'd0:    readdata = 32'(data_q);
            3'd1:    readdata = 32'(sync2_q);
            3'd2:    readdata = 32'(mask_q);
            3'd3:    readdata = 32'(edge_q);
            3'd6:    readdata = 32'(pulse_q);
            3'd7:    readdata = 32'(cnt_q);
            default: readdata = 32'd0;
        endcase
    end

    assign out_port = data_q | pulse_q;
    assign irq      = |(edge_q & mask_q);
endmodule

// File: tb/tb_avalon_pio_ext.sv
// tb_avalon_pio_ext: directed and randomized checks of avalon_pio_ext against a behavioural model
module tb_avalon_pio_ext;
    localparam int RV = 1;
    localparam int PC = 16;

    logic        clk;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [1:0]  in_port;
    logic [1:0]  out_port;
    logic        irq;

    int vecs = 0;
    int errs = 0;

    avalon_pio_ext #(
        .OUT_WIDTH(2), .IN_WIDTH(2), .RESET_VALUE(32'(RV)), .EDGE_TYPE(0), .PULSE_CYCLES(PC)
    ) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .in_port(in_port), .out_port(out_port), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: register values plus a short history of sampled inputs
    logic [1:0] m_data, m_mask, m_edge, m_pulse, m_in;
    int         m_left;
    logic [1:0] hist[$];
    logic       m_wr;
    logic [1:0] m_wd, m_ev, m_clr;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_data = 2'(RV); m_mask = 0; m_edge = 0; m_pulse = 0; m_left = 0; m_in = 0;
            hist.delete();
        end else begin
            m_wr  = chipselect && !write_n;
            m_wd  = writedata[1:0];
            m_ev  = 0;
            if (hist.size() >= 3) m_ev = hist[hist.size()-2] & ~hist[hist.size()-3];
            m_clr = (m_wr && address == 3) ? m_wd : 2'b00;
            m_edge = (m_edge & ~m_clr) | m_ev;
            if (m_wr && address == 0) m_data = m_wd;
            if (m_wr && address == 4) m_data = m_data | m_wd;
            if (m_wr && address == 5) m_data = m_data & ~m_wd;
            if (m_wr && address == 2) m_mask = m_wd;
            if (m_wr && address == 6) begin
                m_pulse = m_wd;
                m_left  = (m_wd != 0) ? PC : 0;
            end else if (m_left > 0) begin
                m_left = m_left - 1;
                if (m_left == 0) m_pulse = 0;
            end
            hist.push_back(in_port);
            if (hist.size() > 3) void'(hist.pop_front());
            m_in = (hist.size() >= 2) ? hist[hist.size()-2] : 2'b00;
        end
    end

    function automatic logic [31:0] exp_rd(input logic [2:0] a);
        case (a)
            3'd0: return 32'(m_data);
            3'd1: return 32'(m_in);
            3'd2: return 32'(m_mask);
            3'd3: return 32'(m_edge);
            3'd6: return 32'(m_pulse);
            3'd7: return 32'(m_left);
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the rising edge
    always @(negedge clk) begin
        chk("model_readdata", readdata, exp_rd(address));
        chk("model_out_port", 32'(out_port), 32'(m_data | m_pulse));
        chk("model_irq", 32'(irq), 32'(|(m_edge & m_mask)));
    end

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        chipselect = 1; write_n = 0; address = a; writedata = d;
        step();
        chipselect = 0; write_n = 1;
    endtask

    task automatic rd_chk(input string name, input logic [2:0] a, input logic [31:0] exp);
        address = a;
        #1;
        chk(name, readdata, exp);
    endtask

    initial begin
        reset = 1; chipselect = 0; write_n = 1; address = 0; writedata = 0; in_port = 0;
        step(); step();
        rd_chk("rst_data", 3'd0, 32'd1);
        chk("rst_out", 32'(out_port), 32'd1);
        chk("rst_irq", 32'(irq), 32'd0);
        reset = 0;
        repeat (4) step();

        wr(0, 32'h3); wr(5, 32'h1); wr(4, 32'h0);
        rd_chk("data_set_clr", 3'd0, 32'd2);
        chk("out_set_clr", 32'(out_port), 32'd2);
        wr(0, 32'hffff_fff0);
        rd_chk("data_wide_write", 3'd0, 32'd0);

        wr(3, 32'h3); wr(2, 32'h1);
        in_port = 2'b01;
        step(); rd_chk("edge_clk1", 3'd3, 32'd0);
        step(); rd_chk("edge_clk2", 3'd3, 32'd0);
        step(); rd_chk("edge_clk3", 3'd3, 32'd1);
        chk("irq_set", 32'(irq), 32'd1);
        rd_chk("input_sync", 3'd1, 32'd1);
        wr(3, 32'h1);
        chk("irq_w1c", 32'(irq), 32'd0);

        wr(6, 32'h1);
        for (int i = 0; i < PC; i++) begin
            chk("pulse_on", 32'(out_port), 32'd1);
            step();
        end
        chk("pulse_off", 32'(out_port), 32'd0);
        rd_chk("pulse_cnt_end", 3'd7, 32'd0);

        wr(6, 32'h1);
        repeat (PC - 1) step();
        rd_chk("pulse_cnt_last", 3'd7, 32'd1);
        wr(6, 32'h2);
        for (int i = 0; i < PC; i++) begin
            chk("pulse_restart", 32'(out_port), 32'd2);
            step();
        end
        chk("pulse_restart_off", 32'(out_port), 32'd0);
        wr(6, 32'h1);
        repeat (3) step();
        wr(6, 32'h0);
        chk("pulse_cancel", 32'(out_port), 32'd0);
        rd_chk("pulse_cancel_cnt", 3'd7, 32'd0);

        in_port = 2'b11;
        step(); step();
        wr(3, 32'h2);
        rd_chk("edge_vs_w1c", 3'd3, 32'd2);

        wr(2, 32'h3);
        chk("irq_before_rst", 32'(irq), 32'd1);
        wr(6, 32'h2);
        step();
        reset = 1;
        #1;
        chk("rst_mid_out", 32'(out_port), 32'd1);
        chk("rst_mid_irq", 32'(irq), 32'd0);
        for (int a = 0; a < 8; a++) begin
            address = 3'(a);
            step();
            chk("rst_mid_reg", readdata, (a == 0) ? 32'd1 : 32'd0);
        end
        reset = 0;
        repeat (6) step();
        rd_chk("no_edge_at_release", 3'd3, 32'd0);
        rd_chk("input_after_release", 3'd1, 32'd3);

        for (int i = 0; i < 3000; i++) begin
            chipselect = $urandom_range(0, 3) != 0;
            write_n    = 1'($urandom_range(0, 1));
            address    = 3'($urandom_range(0, 7));
            writedata  = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) in_port = 2'($urandom_range(0, 3));
            reset      = $urandom_range(0, 299) == 0;
            step();
        end
        reset = 0; chipselect = 0; write_n = 1;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
